// File: rtl/serial_bit_feeder_if.sv
`default_nettype none
// ============================================================================
//  serial_bit_feeder_if : word handshake in, serial bit stream out
//  Revision 1.0
// ============================================================================
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, sout, sout_valid, word_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, sout, sout_valid, word_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  serial_bit_feeder : parallel words to one bit per clk, one-word hold buffer
//  Revision 1.0
// ============================================================================
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  serial_bit_feeder_if.slave  bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;

  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign accept  = bus.in_valid && !hold_full;
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= bus.in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            shreg <= shifted;
            cnt   <= cnt + 1'b1;
            if (accept) begin
              hold      <= bus.in_data;
              hold_full <= 1'b1;
            end
          end else begin
            // Last bit on the wire: chain the next word in without a gap.
            cnt <= '0;
            if (hold_full) begin
              shreg     <= hold;
              hold_full <= 1'b0;
            end else if (accept) begin
              shreg <= bus.in_data;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sout       = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
  assign bus.sout_valid = (state == SHIFT);
  assign bus.word_done  = (state == SHIFT) && (cnt == LAST);
  assign bus.in_ready   = !hold_full;
  assign bus.busy       = (state == SHIFT) || hold_full;

endmodule
`default_nettype wire
